dcache_meta_array: RTL and testbench
====================================

// Module: dcache_meta_array
// PURPOSE
// - L1 data-cache tag/coherence metadata store; directly downstream of the meta-write arbiter
//   (MSHR/prober/writeback requests), consuming its idx/way_en/coh_state/tag write stream.
// - Also serves the pipeline's per-set metadata reads for tag compare.
// - After reset, self-initialises every entry to {coh=Nothing, tag=0} before accepting traffic.
// PARAMETERS
// - N_SETS  64  number of sets; power of two
// - N_WAYS  8   ways per set; width of way_en
// - TAG_W   21  tag field width
// - COH_W   2   coherence state width
// - IDX_W   $clog2(N_SETS) = 6  derived, not overridable
// PORTS
// - clock                       in   1               single clock; all state on rising edge
// - reset                       in   1               asynchronous, active-low (0 = in reset)
// - io_write_ready              out  1               write accepted this cycle if valid
// - io_write_valid              in   1               write request present
// - io_write_bits_idx           in   IDX_W           target set
// - io_write_bits_way_en        in   N_WAYS          one-hot-or-more way mask
// - io_write_bits_data_coh_state in  COH_W           new coherence state
// - io_write_bits_data_tag      in   TAG_W           new tag
// - io_read_ready               out  1               read accepted this cycle if valid
// - io_read_valid               in   1               read request present
// - io_read_bits_idx            in   IDX_W           set to read
// - io_resp_valid               out  1               read data valid (1-cycle pulse)
// - io_resp_coh_state           out  N_WAYS*COH_W    way w at [w*COH_W +: COH_W]
// - io_resp_tag                 out  N_WAYS*TAG_W    way w at [w*TAG_W +: TAG_W]
// - io_init_done                out  1               initialisation sweep complete
// BEHAVIOUR
// - Reset (reset==0): state=INIT, init_cnt=0; outputs: write_ready=0, read_ready=0,
//   resp_valid=0, resp_coh_state=0, resp_tag=0, init_done=0. Array contents undefined until swept.
// - FSM INIT: each cycle writes all N_WAYS of set init_cnt to {0,0}; init_cnt++;
//   after set N_SETS-1 -> RUN (N_SETS cycles total). INIT: write_ready=0, read_ready=0.
// - FSM RUN: terminal until next reset; init_done=1.
// - write_ready = (state==RUN). Write fires on valid&&ready; at that edge every way with
//   way_en[w]=1 takes {coh_state,tag}; other ways unchanged. way_en=0 -> legal no-op.
// - read_ready = (state==RUN) && !io_write_valid (write has priority; single-port array model).
//   Read and write never fire in the same cycle.
// - Read fires at edge t -> resp_valid=1 in cycle t+1 with set contents as of edge t; latency 1.
// - resp_valid is a 1-cycle pulse per fired read; resp data registers hold last value otherwise.
// - Write at edge t, read same idx fired at t+1 -> sees new data (no stale window).
// - Back-to-back reads: one per cycle, resp each following cycle.
// - valid held high with ready low: no state change; requester must hold bits stable.
// - Reset mid-INIT or mid-RUN: asynchronous return to INIT, pending resp dropped (resp_valid=0),
//   full sweep restarts from set 0.
// STRUCTURE
// - Package dcache_meta_pkg: N_SETS/N_WAYS/TAG_W/COH_W defaults, coh encoding
//   (NOTHING=0, BRANCH=1, TRUNK=2, DIRTY=3), meta_entry_t struct {coh, tag},
//   meta_fsm_e {INIT, RUN}.
// - Sub-module meta_way_bank: one way's N_SETS x (COH_W+TAG_W) 1RW storage with registered
//   read; instantiated N_WAYS times. Top holds FSM, init counter, handshake and write muxing.
// TESTING
// - Reset release -> io_init_done rises exactly 64 cycles later; ready signals 0 until then.
// - Post-init read idx=5 -> next cycle resp_valid=1, all 8 ways coh=0, tag=0.
// - Write idx=3 way_en=8'h04 coh=3 tag=21'h1ABCD, read idx=3 next cycle -> way2 {3,1ABCD},
//   other ways {0,0}.
// - write_valid and read_valid both 1 -> read_ready=0, write lands; read accepted the
//   following cycle and returns the new data.
// - Write way_en=8'hFF idx=63 tag=21'h1FFFFF coh=2, read idx=63 and idx=0 -> all ways
//   {2,1FFFFF} at 63, {0,0} at 0 (no wrap aliasing).
// - Assert reset during RUN after writes -> outputs 0 immediately, sweep repeats,
//   read idx=3 afterwards returns {0,0}.

Source files
------------

// File: rtl/dcache_meta_pkg.sv
// Shared geometry defaults, coherence encoding and metadata types for the L1 D-cache
// metadata array.
package dcache_meta_pkg;

    localparam int DEF_N_SETS = 64;
    localparam int DEF_N_WAYS = 8;
    localparam int DEF_TAG_W  = 21;
    localparam int DEF_COH_W  = 2;

    typedef enum logic [DEF_COH_W-1:0] {
        COH_NOTHING = 2'd0,
        COH_BRANCH  = 2'd1,
        COH_TRUNK   = 2'd2,
        COH_DIRTY   = 2'd3
    } coh_e;

    typedef struct packed {
        logic [DEF_COH_W-1:0] coh;
        logic [DEF_TAG_W-1:0] tag;
    } meta_entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } meta_fsm_e;

endpackage

// File: rtl/meta_way_bank.sv
// One way of metadata storage: N_SETS entries, single read/write port, registered read.
module meta_way_bank #(
    parameter int N_SETS = 64,
    parameter int ENT_W  = 23
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [$clog2(N_SETS)-1:0] idx_i,
    input  logic [ENT_W-1:0]          wdata_i,
    output logic [ENT_W-1:0]          rdata_o
);

    logic [ENT_W-1:0] mem [N_SETS];
    logic [ENT_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Read register is reset so the response bus reads as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_meta_array.sv
// L1 D-cache tag/coherence metadata array: self-initialising sweep after reset, then
// write-priority single-port access with a one-cycle registered read response.
module dcache_meta_array
    import dcache_meta_pkg::*;
#(
    parameter int N_SETS = DEF_N_SETS,
    parameter int N_WAYS = DEF_N_WAYS,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int COH_W  = DEF_COH_W
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      io_write_ready,
    input  logic                      io_write_valid,
    input  logic [$clog2(N_SETS)-1:0] io_write_bits_idx,
    input  logic [N_WAYS-1:0]         io_write_bits_way_en,
    input  logic [COH_W-1:0]          io_write_bits_data_coh_state,
    input  logic [TAG_W-1:0]          io_write_bits_data_tag,
    output logic                      io_read_ready,
    input  logic                      io_read_valid,
    input  logic [$clog2(N_SETS)-1:0] io_read_bits_idx,
    output logic                      io_resp_valid,
    output logic [N_WAYS*COH_W-1:0]   io_resp_coh_state,
    output logic [N_WAYS*TAG_W-1:0]   io_resp_tag,
    output logic                      io_init_done
);

    localparam int IDX_W = $clog2(N_SETS);
    localparam int ENT_W = COH_W + TAG_W;

    meta_fsm_e        state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic             resp_valid_q;

    logic             wr_fire, rd_fire;
    logic [N_WAYS-1:0] bank_we;
    logic             bank_re;
    logic [IDX_W-1:0] bank_idx;
    logic [ENT_W-1:0] bank_wdata;
    logic [ENT_W-1:0] bank_rdata [N_WAYS];

    // Writes win the single array port; a read waits while any write is presented.
    assign io_write_ready = (state_q == ST_RUN);
    assign io_read_ready  = (state_q == ST_RUN) && !io_write_valid;
    assign wr_fire        = io_write_valid && io_write_ready;
    assign rd_fire        = io_read_valid && io_read_ready;
    assign io_init_done   = (state_q == ST_RUN);
    assign io_resp_valid  = resp_valid_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        bank_we    = '0;
        bank_re    = 1'b0;
        bank_idx   = io_read_bits_idx;
        bank_wdata = {io_write_bits_data_coh_state, io_write_bits_data_tag};
        case (state_q)
            ST_INIT: begin
                bank_we    = '1;
                bank_idx   = init_cnt_q;
                bank_wdata = {COH_W'(COH_NOTHING), {TAG_W{1'b0}}};
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == IDX_W'(N_SETS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_fire) begin
                    bank_we  = io_write_bits_way_en;
                    bank_idx = io_write_bits_idx;
                end
                bank_re = rd_fire;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            resp_valid_q <= rd_fire;
        end
    end

    for (genvar w = 0; w < N_WAYS; w++) begin : g_way
        meta_way_bank #(
            .N_SETS (N_SETS),
            .ENT_W  (ENT_W)
        ) u_bank (
            .clk_i   (clock),
            .rst_ni  (reset),
            .we_i    (bank_we[w]),
            .re_i    (bank_re),
            .idx_i   (bank_idx),
            .wdata_i (bank_wdata),
            .rdata_o (bank_rdata[w])
        );

        assign io_resp_coh_state[w*COH_W +: COH_W] = bank_rdata[w][ENT_W-1 -: COH_W];
        assign io_resp_tag[w*TAG_W +: TAG_W]       = bank_rdata[w][TAG_W-1:0];
    end

endmodule

// File: tb/tb_dcache_meta_array.sv
// Directed bench for dcache_meta_array: init sweep timing, read/write handshake,
// write priority, set boundaries and reset during operation.
module tb_dcache_meta_array;

    logic         clock;
    logic         reset;
    logic         io_write_ready;
    logic         io_write_valid;
    logic [5:0]   io_write_bits_idx;
    logic [7:0]   io_write_bits_way_en;
    logic [1:0]   io_write_bits_data_coh_state;
    logic [20:0]  io_write_bits_data_tag;
    logic         io_read_ready;
    logic         io_read_valid;
    logic [5:0]   io_read_bits_idx;
    logic         io_resp_valid;
    logic [15:0]  io_resp_coh_state;
    logic [167:0] io_resp_tag;
    logic         io_init_done;

    int checks   = 0;
    int failures = 0;

    dcache_meta_array dut (
        .clock                        (clock),
        .reset                        (reset),
        .io_write_ready               (io_write_ready),
        .io_write_valid               (io_write_valid),
        .io_write_bits_idx            (io_write_bits_idx),
        .io_write_bits_way_en         (io_write_bits_way_en),
        .io_write_bits_data_coh_state (io_write_bits_data_coh_state),
        .io_write_bits_data_tag       (io_write_bits_data_tag),
        .io_read_ready                (io_read_ready),
        .io_read_valid                (io_read_valid),
        .io_read_bits_idx             (io_read_bits_idx),
        .io_resp_valid                (io_resp_valid),
        .io_resp_coh_state            (io_resp_coh_state),
        .io_resp_tag                  (io_resp_tag),
        .io_init_done                 (io_init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_resp(input string tag, input logic [15:0] coh, input logic [167:0] tg);
        check({tag, "_valid"}, io_resp_valid, 1'b1);
        check({tag, "_coh"}, io_resp_coh_state, coh);
        check({tag, "_tag"}, io_resp_tag, tg);
    endtask

    task automatic do_write(input logic [5:0] idx, input logic [7:0] way_en,
                            input logic [1:0] coh, input logic [20:0] tg);
        io_write_valid               = 1'b1;
        io_write_bits_idx            = idx;
        io_write_bits_way_en         = way_en;
        io_write_bits_data_coh_state = coh;
        io_write_bits_data_tag       = tg;
        tick();
        io_write_valid = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] idx);
        io_read_valid    = 1'b1;
        io_read_bits_idx = idx;
        tick();
        io_read_valid = 1'b0;
    endtask

    task automatic sweep_after_release(input string tag);
        repeat (63) tick();
        check({tag, "_done_early"}, io_init_done, 1'b0);
        check({tag, "_wready_early"}, io_write_ready, 1'b0);
        check({tag, "_rready_early"}, io_read_ready, 1'b0);
        tick();
        check({tag, "_done_at_64"}, io_init_done, 1'b1);
        check({tag, "_wready_at_64"}, io_write_ready, 1'b1);
        check({tag, "_rready_at_64"}, io_read_ready, 1'b1);
    endtask

    initial begin
        reset                        = 1'b0;
        io_write_valid               = 1'b0;
        io_write_bits_idx            = '0;
        io_write_bits_way_en         = '0;
        io_write_bits_data_coh_state = '0;
        io_write_bits_data_tag       = '0;
        io_read_valid                = 1'b0;
        io_read_bits_idx             = '0;

        tick();
        tick();
        check("rst_wready", io_write_ready, 1'b0);
        check("rst_rready", io_read_ready, 1'b0);
        check("rst_resp_valid", io_resp_valid, 1'b0);
        check("rst_resp_coh", io_resp_coh_state, 16'h0);
        check("rst_resp_tag", io_resp_tag, 168'h0);
        check("rst_init_done", io_init_done, 1'b0);

        reset = 1'b1;
        sweep_after_release("init");

        do_read(6'd5);
        check_resp("rd5", 16'h0, 168'h0);
        tick();
        check("rd5_pulse_end", io_resp_valid, 1'b0);

        // way 2: coh at bits [5:4], tag at bits [62:42]
        do_write(6'd3, 8'h04, 2'd3, 21'h1ABCD);
        do_read(6'd3);
        check_resp("rd3", 16'h0030, 168'h1ABCD << 42);

        io_write_valid               = 1'b1;
        io_write_bits_idx            = 6'd10;
        io_write_bits_way_en         = 8'h01;
        io_write_bits_data_coh_state = 2'd1;
        io_write_bits_data_tag       = 21'h00055;
        io_read_valid                = 1'b1;
        io_read_bits_idx             = 6'd10;
        #1;
        check("prio_rready", io_read_ready, 1'b0);
        check("prio_wready", io_write_ready, 1'b1);
        tick();
        io_write_valid = 1'b0;
        #1;
        check("prio_no_resp", io_resp_valid, 1'b0);
        check("prio_rready_after", io_read_ready, 1'b1);
        tick();
        io_read_valid = 1'b0;
        check_resp("prio_rd10", 16'h0001, 168'h55);

        do_write(6'd63, 8'hFF, 2'd2, 21'h1FFFFF);
        io_read_valid    = 1'b1;
        io_read_bits_idx = 6'd0;
        tick();
        check_resp("rd0", 16'h0, 168'h0);
        io_read_bits_idx = 6'd63;
        tick();
        io_read_valid = 1'b0;
        check_resp("rd63", 16'hAAAA, {168{1'b1}});
        tick();
        check("hold_valid", io_resp_valid, 1'b0);
        check("hold_tag", io_resp_tag, {168{1'b1}});

        do_write(6'd3, 8'h00, 2'd1, 21'h1FFFFF);
        do_read(6'd3);
        check_resp("noop_rd3", 16'h0030, 168'h1ABCD << 42);

        io_read_valid    = 1'b1;
        io_read_bits_idx = 6'd3;
        tick();
        io_read_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_resp_valid", io_resp_valid, 1'b0);
        check("mid_rst_resp_coh", io_resp_coh_state, 16'h0);
        check("mid_rst_resp_tag", io_resp_tag, 168'h0);
        check("mid_rst_init_done", io_init_done, 1'b0);
        check("mid_rst_wready", io_write_ready, 1'b0);
        tick();
        reset = 1'b1;
        sweep_after_release("reinit");
        do_read(6'd3);
        check_resp("post_rst_rd3", 16'h0, 168'h0);
        do_read(6'd63);
        check_resp("post_rst_rd63", 16'h0, 168'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
